fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - IF stage of the 5-stage MIPS pipeline. Owns the PC and fetches from instruction memory over a req/rvalid handshake.
// - Drives the IF/ID register (DR, PC_ID, PC4, valid). DR feeds the ID-stage instruction-type decoder and control unit.
// - Supports ID back-pressure (id_stall) via a 1-entry skid register, and branch/jump redirect with flush.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC fetched first after reset
// - NOP_INSTR  32'h0000_0000  word driven on DR for bubbles/flush (sll $0,$0,0)
// PORTS
// - clk          in   1   single clock, all state on rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - imem_req     out  1   fetch request, level; held until imem_rvalid
// - imem_addr    out  32  word address (bits[1:0]=0), stable while imem_req=1
// - imem_rvalid  in   1   response strobe, earliest 1 cycle after req rises
// - imem_rdata   in   32  instruction word, valid with imem_rvalid
// - redirect     in   1   branch/jump taken: flush and refetch
// - redirect_pc  in   32  target; bits[1:0] ignored (forced 0)
// - id_stall     in   1   ID cannot accept DR this cycle
// - DR           out  32  fetched instruction to ID
// - PC_ID        out  32  address of the instruction in DR
// - PC4          out  32  PC_ID+4 (for JAL link / branch base)
// - valid        out  1   DR holds a real instruction
// BEHAVIOUR
// - Reset (async): pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, DR=NOP_INSTR, PC_ID=0, PC4=0, valid=0, skid empty, discard=0.
// - States: S_IDLE, S_WAIT, S_SKID.
// - S_IDLE: imem_req=0; next cycle -> S_WAIT.
// - S_WAIT: imem_req=1, imem_addr=pc. On imem_rvalid:
//   - discard=1: drop data, clear discard, stay S_WAIT (req re-issued at the current pc the next cycle).
//   - IF/ID free (valid=0 or id_stall=0): DR<=rdata, PC_ID<=pc, PC4<=pc+4, valid<=1, pc<=pc+4.
//   - IF/ID occupied and stalled: skid<=rdata, skid_pc<=pc, pc<=pc+4, -> S_SKID.
// - imem_req deasserts in the cycle after rvalid, for exactly 1 cycle. It reasserts with the new address. Throughput is 1 instr / 2 cycles at 1-cycle memory latency.
// - S_SKID: imem_req=0. When id_stall=0: DR<=skid, PC_ID<=skid_pc, PC4<=skid_pc+4, valid<=1, -> S_WAIT.
// - ID consumes DR on a cycle with valid=1 and id_stall=0. If no new word loads that cycle: DR<=NOP_INSTR, valid<=0.
// - id_stall with valid=0 has no effect; IF/ID loads normally.
// - Redirect, highest priority, same cycle:
//   - pc<=redirect_pc&~3; DR<=NOP_INSTR; valid<=0; skid emptied.
//   - If a request is outstanding and imem_rvalid=0: discard<=1.
//   - If imem_rvalid=1 that cycle: the data is dropped and discard stays 0.
//   - State -> S_WAIT, or -> S_IDLE if in S_SKID/S_IDLE.
// - Redirect beats id_stall; flushed word is never presented.
// - Redirect during discard=1: discard stays 1; only one stale response is ever outstanding.
// - pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
// - imem_addr[1:0] is always 0. imem_addr never changes while imem_req=1 and no rvalid has been seen.
// TESTING
// - Reset release, mem latency 1, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8..., DR/PC_ID pairs match, valid pulses every 2nd cycle.
// - id_stall=1 for 5 cycles with valid=1 -> DR/PC_ID frozen, second word held in skid, no req. On release, skid word appears next cycle, no loss/duplication.
// - redirect to 32'h0000_0103 while a req is outstanding (latency 3) -> stale word dropped, next imem_addr=32'h100, valid=0 until 32'h100 returns.
// - redirect in same cycle as imem_rvalid and id_stall=1 -> DR=NOP_INSTR, valid=0, data discarded, discard=0, refetch target.
// - RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; PC4 of FFFF_FFFC is 0.
// - rst_n low mid-S_SKID and mid-S_WAIT -> all outputs at reset values immediately (async), fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/rvalid bus between IF stage and imem
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, imem fetch, 1-entry skid, redirect/flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 id_stall,
  output logic [31:0]          DR,
  output logic [31:0]          PC_ID,
  output logic [31:0]          PC4,
  output logic                 valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SKID} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] dr_d, pc_id_d, pc4_d;
  logic        valid_d;
  logic [31:0] skid, skid_d, skid_pc, skid_pc_d;
  // set when a response already in flight belongs to a flushed fetch
  logic        discard, discard_d;

  // the request is a level held for the whole S_WAIT residency
  assign imem.req  = (state == S_WAIT);
  assign imem.addr = {pc[31:2], 2'b00};

  // next-state, IF/ID load, skid and redirect handling
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    dr_d      = DR;
    pc_id_d   = PC_ID;
    pc4_d     = PC4;
    valid_d   = valid;
    skid_d    = skid;
    skid_pc_d = skid_pc;
    discard_d = discard;

    // ID takes the current word; becomes a bubble unless refilled below
    if (valid && !id_stall) begin
      dr_d    = NOP_INSTR;
      valid_d = 1'b0;
    end

    case (state)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (imem.rvalid) begin
          discard_d = 1'b0;
          if (discard) begin
            state_d = S_WAIT;
          end else if (!valid || !id_stall) begin
            dr_d    = imem.rdata;
            pc_id_d = pc;
            pc4_d   = pc + 32'd4;
            valid_d = 1'b1;
            pc_d    = pc + 32'd4;
            state_d = S_IDLE;
          end else begin
            skid_d    = imem.rdata;
            skid_pc_d = pc;
            pc_d      = pc + 32'd4;
            state_d   = S_SKID;
          end
        end
      end
      S_SKID: begin
        if (!id_stall) begin
          dr_d    = skid;
          pc_id_d = skid_pc;
          pc4_d   = skid_pc + 32'd4;
          valid_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // redirect overrides everything: flush IF/ID and skid, refetch target
    if (redirect) begin
      pc_d    = redirect_pc & ~32'd3;
      dr_d    = NOP_INSTR;
      valid_d = 1'b0;
      if (state == S_WAIT) begin
        state_d   = S_WAIT;
        discard_d = !imem.rvalid;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // state and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      DR      <= NOP_INSTR;
      PC_ID   <= 32'd0;
      PC4     <= 32'd0;
      valid   <= 1'b0;
      skid    <= NOP_INSTR;
      skid_pc <= 32'd0;
      discard <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      DR      <= dr_d;
      PC_ID   <= pc_id_d;
      PC4     <= pc4_d;
      valid   <= valid_d;
      skid    <= skid_d;
      skid_pc <= skid_pc_d;
      discard <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic [31:0] DR, PC_ID, PC4;
  logic        valid;

  logic [31:0] w_dr, w_pc_id, w_pc4;
  logic        w_valid;

  fetch_stage_if imem_bus ();
  fetch_stage_if w_bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst_n(rst_n), .imem(imem_bus.master),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .DR(DR), .PC_ID(PC_ID), .PC4(PC4), .valid(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem(w_bus.master),
    .redirect(1'b0), .redirect_pc(32'd0), .id_stall(1'b0),
    .DR(w_dr), .PC_ID(w_pc_id), .PC4(w_pc4), .valid(w_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // memory model and reference state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_q;
  int          fixed_lat;
  logic        last_rv;
  logic [31:0] exp_pc;
  int          n_cons;

  logic [31:0] w_pcs [4];
  logic [31:0] w_pc4s [4];
  int          n_w = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // 1-cycle memory for the wrap instance; records the first few delivered words
  always @(negedge clk) begin
    w_bus.rvalid = w_bus.req && rst_n;
    w_bus.rdata  = w_bus.addr ^ KEY;
    if (rst_n && w_valid && n_w < 4) begin
      w_pcs[n_w]  = w_pc_id;
      w_pc4s[n_w] = w_pc4;
      n_w++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: drive memory/stall/redirect at negedge, check at the next negedge
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] tgt);
    logic [31:0] p_dr, p_pcid, p_addr;
    logic        p_valid, p_req, rv;
    rv = 1'b0;
    if (!mem_busy && imem_bus.req) begin
      mem_busy   = 1'b1;
      mem_addr_q = imem_bus.addr;
      mem_cnt    = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv       = 1'b1;
        mem_busy = 1'b0;
      end
    end
    imem_bus.rvalid = rv;
    imem_bus.rdata  = rv ? (mem_addr_q ^ KEY) : $urandom;
    id_stall    = stall;
    redirect    = redir;
    redirect_pc = tgt;
    last_rv     = rv;
    p_dr    = DR;
    p_pcid  = PC_ID;
    p_valid = valid;
    p_req   = imem_bus.req;
    p_addr  = imem_bus.addr;
    @(negedge clk);
    if (p_valid && !stall) begin
      check("cons_pc", p_pcid, exp_pc);
      check("cons_dr", p_dr, exp_pc ^ KEY);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (redir) begin
      exp_pc = tgt & ~32'd3;
      check("flush_valid", 32'(valid), 32'd0);
      check("flush_dr", DR, NOP);
    end else if (p_valid && stall) begin
      check("hold_dr", DR, p_dr);
      check("hold_pc", PC_ID, p_pcid);
      check("hold_valid", 32'(valid), 32'd1);
    end
    if (valid) begin
      check("pc_id", PC_ID, exp_pc);
      check("dr", DR, exp_pc ^ KEY);
      check("pc4", PC4, exp_pc + 32'd4);
    end
    if (imem_bus.req) check("addr_align", 32'(imem_bus.addr[1:0]), 32'd0);
    if (p_req && imem_bus.req && !rv && !redir) check("addr_stable", imem_bus.addr, p_addr);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 12 && !valid; i++) cycle(1'b0, 1'b0, 32'd0);
    check(tag, 32'(valid), 32'd1);
  endtask

  // asynchronous reset asserted between clock edges
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_dr"}, DR, NOP);
    check({tag, "_pcid"}, PC_ID, 32'd0);
    check({tag, "_pc4"}, PC4, 32'd0);
    check({tag, "_req"}, 32'(imem_bus.req), 32'd0);
    check({tag, "_addr"}, imem_bus.addr, 32'd0);
    mem_busy = 1'b0;
    imem_bus.rvalid = 1'b0;
    id_stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    exp_pc = 32'd0;
    cycle(1'b0, 1'b0, 32'd0);
    check({tag, "_restart_req"}, 32'(imem_bus.req), 32'd1);
    check({tag, "_restart_addr"}, imem_bus.addr, 32'd0);
  endtask

  initial begin
    int vcount;
    int found;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    id_stall = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata = 32'd0;
    mem_busy = 1'b0;
    mem_cnt = 0;
    mem_addr_q = 32'd0;
    fixed_lat = 1;
    exp_pc = 32'd0;
    n_cons = 0;
    last_rv = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dr", DR, NOP);
    check("rst_pcid", PC_ID, 32'd0);
    check("rst_pc4", PC4, 32'd0);
    check("rst_req", 32'(imem_bus.req), 32'd0);
    check("rst_addr", imem_bus.addr, 32'd0);
    rst_n = 1'b1;

    // streaming at latency 1: one instruction every two cycles
    repeat (4) cycle(1'b0, 1'b0, 32'd0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      if (valid) vcount++;
    end
    check("throughput", 32'(vcount), 32'd10);

    // wrap-around instance
    check("wrap_count", 32'(n_w >= 3), 32'd1);
    check("wrap_pc0", w_pcs[0], 32'hFFFF_FFF8);
    check("wrap_pc1", w_pcs[1], 32'hFFFF_FFFC);
    check("wrap_pc2", w_pcs[2], 32'h0000_0000);
    check("wrap_pc4_0", w_pc4s[0], 32'hFFFF_FFFC);
    check("wrap_pc4_1", w_pc4s[1], 32'h0000_0000);

    // stall for 5 cycles: second word parks in skid, no request meanwhile
    wait_valid("skid_wait");
    repeat (5) cycle(1'b1, 1'b0, 32'd0);
    check("skid_no_req", 32'(imem_bus.req), 32'd0);
    check("skid_valid", 32'(valid), 32'd1);
    cycle(1'b0, 1'b0, 32'd0);
    check("skid_out", 32'(valid), 32'd1);

    // redirect while a latency-3 request is outstanding
    fixed_lat = 3;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      if (imem_bus.req && mem_busy && mem_cnt >= 2) found = 1;
    end
    check("outstanding_found", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h0000_0103);
    check("redir_req", 32'(imem_bus.req), 32'd1);
    check("redir_addr", imem_bus.addr, 32'h0000_0100);
    wait_valid("redir_fill");
    check("redir_first", PC_ID, 32'h0000_0100);

    // redirect coinciding with rvalid and id_stall
    fixed_lat = 1;
    cycle(1'b0, 1'b0, 32'd0);
    wait_valid("coin_wait");
    cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("coin_rv", 32'(last_rv), 32'd1);
    check("coin_req", 32'(imem_bus.req), 32'd1);
    check("coin_addr", imem_bus.addr, 32'h0000_0200);
    cycle(1'b0, 1'b0, 32'd0);
    check("coin_no_discard", 32'(valid), 32'd1);
    check("coin_pc", PC_ID, 32'h0000_0200);

    // async reset while parked in the skid state
    wait_valid("rs_wait");
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    do_reset("rst_skid");

    // async reset while waiting on a slow response
    fixed_lat = 3;
    for (int i = 0; i < 6 && !(imem_bus.req && mem_busy); i++) cycle(1'b0, 1'b0, 32'd0);
    check("rw_busy", 32'(imem_bus.req && mem_busy), 32'd1);
    do_reset("rst_wait");

    // randomized traffic
    fixed_lat = 0;
    n_cons = 0;
    for (int i = 0; i < 600; i++) begin
      logic st, rd;
      logic [31:0] tg;
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 24) == 0);
      tg = $urandom_range(0, 1023);
      cycle(st, rd, tg);
    end
    check("progress", 32'(n_cons >= 40), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
